fetch_arbiter_rr: RTL and testbench

Parametrised instruction-fetch arbiter between the per-wavefront instruction buffers and the instruction cache. Each cycle it selects one eligible wavefront for fetch, using either rotating round-robin or fixed lowest-ID priority. It tracks outstanding icache requests with a credit counter and a per-wavefront pending bit. It also supports icache back-pressure (valid/ready) and reports ID-tagged acknowledges.

---
 rtl/fetch_arb_pkg.sv | 13 +
 rtl/rr_prio_enc.sv | 41 ++++
 rtl/fetch_arbiter_rr.sv | 118 +++++++++++
 tb/tb_fetch_arbiter_rr.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_arb_pkg.sv
// Shared definitions for the instruction-fetch arbiter.
//   - Default sizing for wavefront slots, ID width and outstanding icache requests.
//   - Arbitration mode encodings driven on arb_mode.
package fetch_arb_pkg;

  localparam int unsigned NUM_WF_DEF          = 40;
  localparam int unsigned WF_ID_W_DEF         = 6;
  localparam int unsigned MAX_OUTSTANDING_DEF = 31;

  localparam logic ARB_RR    = 1'b0;
  localparam logic ARB_FIXED = 1'b1;

endpackage

// File: rtl/rr_prio_enc.sv
// Rotating priority encoder.
//   req_i    : request vector, bit k = requester k
//   start_i  : highest-priority index; search runs upward from here and wraps to 0
//   gnt_id_o : index of the selected requester (0 when nothing requests)
//   valid_o  : at least one request is set
// With start_i = 0 this degenerates to a plain lowest-index-wins encoder.
module rr_prio_enc #(
  parameter int unsigned N    = 40,
  parameter int unsigned ID_W = 6
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] start_i,
  output logic [ID_W-1:0] gnt_id_o,
  output logic            valid_o
);

  logic [ID_W-1:0] hi_id;
  logic [ID_W-1:0] lo_id;
  logic            hi_valid;

  // Two lowest-index searches: one restricted to indices >= start_i, one over
  // everything. The restricted hit wins; otherwise the search has wrapped.
  always_comb begin
    hi_id    = '0;
    lo_id    = '0;
    hi_valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        lo_id = ID_W'(i);
        if (ID_W'(i) >= start_i) begin
          hi_id    = ID_W'(i);
          hi_valid = 1'b1;
        end
      end
    end
  end

  assign gnt_id_o = hi_valid ? hi_id : lo_id;
  assign valid_o  = |req_i;

endmodule

// File: rtl/fetch_arbiter_rr.sv
// Instruction-fetch arbiter between per-wavefront instruction buffers and the icache.
//   clk             : clock, all state on the rising edge
//   rst             : asynchronous active-low reset
//   queue_vfull     : bit k set -> wavefront k instruction buffer full
//   vacant          : bit k set -> slot k holds no wavefront
//   arb_mode        : ARB_RR rotating round-robin, ARB_FIXED lowest ID wins
//   fetch_ready     : icache accepts a request this cycle
//   icache_ack      : one fetch returned, tagged with icache_ack_wfid
//   fetch_valid     : request presented (combinational)
//   pc_select       : selected wavefront, meaningful only with fetch_valid
//   credits         : free icache request credits
//   ack_err         : sticky flag for acks that match no outstanding request
module fetch_arbiter_rr
  import fetch_arb_pkg::*;
#(
  parameter int unsigned NUM_WF          = NUM_WF_DEF,
  parameter int unsigned WF_ID_W         = WF_ID_W_DEF,
  parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
  parameter int unsigned CRED_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_WF-1:0]  queue_vfull,
  input  logic [NUM_WF-1:0]  vacant,
  input  logic               arb_mode,
  input  logic               fetch_ready,
  input  logic               icache_ack,
  input  logic [WF_ID_W-1:0] icache_ack_wfid,
  output logic               fetch_valid,
  output logic [WF_ID_W-1:0] pc_select,
  output logic [CRED_W-1:0]  credits,
  output logic               ack_err
);

  logic [NUM_WF-1:0]  pending_q, pending_d;
  logic [CRED_W-1:0]  credits_q, credits_d;
  logic [WF_ID_W-1:0] ptr_q, ptr_d;
  logic               ack_err_q, ack_err_d;

  logic [NUM_WF-1:0]  eligible;
  logic [WF_ID_W-1:0] start_idx;
  logic [WF_ID_W-1:0] sel_id;
  logic               any_elig;
  logic               grant;
  logic               ack_ok;
  logic [NUM_WF-1:0]  gnt_vec;
  logic [NUM_WF-1:0]  ack_vec;

  assign eligible  = ~queue_vfull & ~vacant & ~pending_q;
  // Fixed priority is the rotating search anchored at slot 0.
  assign start_idx = (arb_mode == ARB_FIXED) ? '0 : ptr_q;

  rr_prio_enc #(
    .N    (NUM_WF),
    .ID_W (WF_ID_W)
  ) u_enc (
    .req_i    (eligible),
    .start_i  (start_idx),
    .gnt_id_o (sel_id),
    .valid_o  (any_elig)
  );

  assign fetch_valid = (credits_q != '0) && any_elig;
  assign pc_select   = sel_id;
  assign grant       = fetch_valid && fetch_ready;

  // One-hot decodes of the granted and acknowledged slots. An out-of-range
  // ack ID decodes to all zeros and therefore never matches a pending bit.
  always_comb begin
    gnt_vec = '0;
    ack_vec = '0;
    for (int k = 0; k < NUM_WF; k++) begin
      gnt_vec[k] = grant && (sel_id == WF_ID_W'(k));
      ack_vec[k] = icache_ack && (icache_ack_wfid == WF_ID_W'(k));
    end
  end

  assign ack_ok = (|(ack_vec & pending_q)) && (credits_q < CRED_W'(MAX_OUTSTANDING));

  always_comb begin
    pending_d = pending_q | gnt_vec;
    if (ack_ok) begin
      pending_d = pending_d & ~ack_vec;
    end

    credits_d = credits_q;
    unique case ({grant, ack_ok})
      2'b10:   credits_d = credits_q - CRED_W'(1);
      2'b01:   credits_d = credits_q + CRED_W'(1);
      default: credits_d = credits_q;
    endcase

    ptr_d = ptr_q;
    if (grant) begin
      ptr_d = (sel_id == WF_ID_W'(NUM_WF - 1)) ? '0 : sel_id + WF_ID_W'(1);
    end

    ack_err_d = ack_err_q | (icache_ack && !ack_ok);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= '0;
      credits_q <= CRED_W'(MAX_OUTSTANDING);
      ptr_q     <= '0;
      ack_err_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      credits_q <= credits_d;
      ptr_q     <= ptr_d;
      ack_err_q <= ack_err_d;
    end
  end

  assign credits = credits_q;
  assign ack_err = ack_err_q;

endmodule

// File: tb/tb_fetch_arbiter_rr.sv
// Directed bench for fetch_arbiter_rr: one default-sized instance plus one
// with two credits for the exhaustion scenario.
module tb_fetch_arbiter_rr;
  import fetch_arb_pkg::*;

  localparam int unsigned NW = 40;
  localparam int unsigned IW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [NW-1:0] queue_vfull;
  logic [NW-1:0] vacant;
  logic          arb_mode;
  logic          fetch_ready;
  logic          icache_ack;
  logic [IW-1:0] icache_ack_wfid;
  logic          fetch_valid;
  logic [IW-1:0] pc_select;
  logic [4:0]    credits;
  logic          ack_err;

  logic          fetch_ready2;
  logic          icache_ack2;
  logic [IW-1:0] icache_ack_wfid2;
  logic          fetch_valid2;
  logic [IW-1:0] pc_select2;
  logic [1:0]    credits2;
  logic          ack_err2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_arbiter_rr #(
    .NUM_WF          (40),
    .WF_ID_W         (6),
    .MAX_OUTSTANDING (31)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .queue_vfull     (queue_vfull),
    .vacant          (vacant),
    .arb_mode        (arb_mode),
    .fetch_ready     (fetch_ready),
    .icache_ack      (icache_ack),
    .icache_ack_wfid (icache_ack_wfid),
    .fetch_valid     (fetch_valid),
    .pc_select       (pc_select),
    .credits         (credits),
    .ack_err         (ack_err)
  );

  fetch_arbiter_rr #(
    .NUM_WF          (40),
    .WF_ID_W         (6),
    .MAX_OUTSTANDING (2)
  ) dut2 (
    .clk             (clk),
    .rst             (rst),
    .queue_vfull     (queue_vfull),
    .vacant          (vacant),
    .arb_mode        (arb_mode),
    .fetch_ready     (fetch_ready2),
    .icache_ack      (icache_ack2),
    .icache_ack_wfid (icache_ack_wfid2),
    .fetch_valid     (fetch_valid2),
    .pc_select       (pc_select2),
    .credits         (credits2),
    .ack_err         (ack_err2)
  );

  task automatic idle_inputs();
    fetch_ready      = 1'b0;
    icache_ack       = 1'b0;
    icache_ack_wfid  = '0;
    fetch_ready2     = 1'b0;
    icache_ack2      = 1'b0;
    icache_ack_wfid2 = '0;
  endtask

  // Mark exactly the slots in m as occupied and not full.
  task automatic elig(input logic [NW-1:0] m);
    vacant      = ~m;
    queue_vfull = '0;
  endtask

  task automatic test_reset();
    rst      = 1'b0;
    arb_mode = ARB_RR;
    idle_inputs();
    vacant      = '1;
    queue_vfull = '0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL reset_valid_vacant got=%0b exp=0", fetch_valid); end
    total++; if (credits !== 5'd31) begin bad++; $display("FAIL reset_credits got=%0d exp=31", credits); end
    total++; if (ack_err !== 1'b0) begin bad++; $display("FAIL reset_ack_err got=%0b exp=0", ack_err); end
    total++; if (credits2 !== 2'd2) begin bad++; $display("FAIL reset_credits2 got=%0d exp=2", credits2); end
    vacant = '0;
    #1;
    total++; if (fetch_valid !== 1'b1) begin bad++; $display("FAIL reset_valid_occ got=%0b exp=1", fetch_valid); end
    total++; if (pc_select !== 6'd0) begin bad++; $display("FAIL reset_pc got=%0d exp=0", pc_select); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_rr_sequence();
    logic [IW-1:0] exp_pc;
    logic [4:0]    exp_cr;
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk);
      elig('1);
      fetch_ready     = 1'b1;
      icache_ack      = (i > 0);
      icache_ack_wfid = IW'((i + 39) % 40);
      exp_pc = IW'(i % 40);
      exp_cr = (i == 0) ? 5'd31 : 5'd30;
      #1;
      total++; if (fetch_valid !== 1'b1) begin bad++; $display("FAIL rr_valid[%0d] got=%0b exp=1", i, fetch_valid); end
      total++; if (pc_select !== exp_pc) begin bad++; $display("FAIL rr_pc[%0d] got=%0d exp=%0d", i, pc_select, exp_pc); end
      total++; if (credits !== exp_cr) begin bad++; $display("FAIL rr_credits[%0d] got=%0d exp=%0d", i, credits, exp_cr); end
    end
    @(negedge clk);
    fetch_ready     = 1'b0;
    icache_ack      = 1'b1;
    icache_ack_wfid = 6'd0;
    #1;
    total++; if (credits !== 5'd30) begin bad++; $display("FAIL rr_tail_credits got=%0d exp=30", credits); end
    @(negedge clk);
    icache_ack = 1'b0;
    #1;
    total++; if (credits !== 5'd31) begin bad++; $display("FAIL rr_final_credits got=%0d exp=31", credits); end
    total++; if (ack_err !== 1'b0) begin bad++; $display("FAIL rr_ack_err got=%0b exp=0", ack_err); end
  endtask

  task automatic test_wrap();
    logic [NW-1:0] m;
    // Grant slot 10 to move the pointer to 11.
    @(negedge clk);
    m = '0; m[10] = 1'b1; elig(m);
    fetch_ready = 1'b1;
    #1;
    total++; if (pc_select !== 6'd10) begin bad++; $display("FAIL wrap_pc10 got=%0d exp=10", pc_select); end
    @(negedge clk);
    m = '0; m[5] = 1'b1; m[39] = 1'b1; elig(m);
    icache_ack      = 1'b1;
    icache_ack_wfid = 6'd10;
    #1;
    total++; if (pc_select !== 6'd39) begin bad++; $display("FAIL wrap_pc39 got=%0d exp=39", pc_select); end
    total++; if (credits !== 5'd30) begin bad++; $display("FAIL wrap_credits_a got=%0d exp=30", credits); end
    @(negedge clk);
    icache_ack = 1'b0;
    #1;
    total++; if (pc_select !== 6'd5) begin bad++; $display("FAIL wrap_pc5 got=%0d exp=5", pc_select); end
    total++; if (credits !== 5'd30) begin bad++; $display("FAIL wrap_credits_b got=%0d exp=30", credits); end
    @(negedge clk);
    fetch_ready = 1'b0;
    m = '0; m[3] = 1'b1; m[6] = 1'b1; elig(m);
    #1;
    total++; if (credits !== 5'd29) begin bad++; $display("FAIL wrap_credits_c got=%0d exp=29", credits); end
    total++; if (pc_select !== 6'd6) begin bad++; $display("FAIL wrap_ptr6 got=%0d exp=6", pc_select); end
    @(negedge clk);
    icache_ack      = 1'b1;
    icache_ack_wfid = 6'd39;
    @(negedge clk);
    icache_ack_wfid = 6'd5;
    @(negedge clk);
    icache_ack = 1'b0;
    #1;
    total++; if (credits !== 5'd31) begin bad++; $display("FAIL wrap_restore got=%0d exp=31", credits); end
    total++; if (ack_err !== 1'b0) begin bad++; $display("FAIL wrap_ack_err got=%0b exp=0", ack_err); end
  endtask

  task automatic test_same_cycle();
    logic [NW-1:0] m;
    @(negedge clk);
    m = '0; m[1] = 1'b1; elig(m);
    fetch_ready = 1'b1;
    #1;
    total++; if (pc_select !== 6'd1) begin bad++; $display("FAIL sc_pc1 got=%0d exp=1", pc_select); end
    // Ack frees slot 1, but it is not re-eligible until the next cycle.
    @(negedge clk);
    icache_ack      = 1'b1;
    icache_ack_wfid = 6'd1;
    #1;
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL sc_freed_late got=%0b exp=0", fetch_valid); end
    total++; if (credits !== 5'd30) begin bad++; $display("FAIL sc_credits_a got=%0d exp=30", credits); end
    @(negedge clk);
    icache_ack = 1'b0;
    #1;
    total++; if (fetch_valid !== 1'b1) begin bad++; $display("FAIL sc_freed_now got=%0b exp=1", fetch_valid); end
    total++; if (credits !== 5'd31) begin bad++; $display("FAIL sc_credits_b got=%0d exp=31", credits); end
    @(negedge clk);
    m = '0; m[3] = 1'b1; elig(m);
    icache_ack      = 1'b1;
    icache_ack_wfid = 6'd1;
    #1;
    total++; if (pc_select !== 6'd3) begin bad++; $display("FAIL sc_pc3 got=%0d exp=3", pc_select); end
    total++; if (credits !== 5'd30) begin bad++; $display("FAIL sc_credits_c got=%0d exp=30", credits); end
    @(negedge clk);
    icache_ack  = 1'b0;
    fetch_ready = 1'b0;
    m = '0; m[1] = 1'b1; m[3] = 1'b1; elig(m);
    #1;
    total++; if (credits !== 5'd30) begin bad++; $display("FAIL sc_credits_same got=%0d exp=30", credits); end
    total++; if (pc_select !== 6'd1) begin bad++; $display("FAIL sc_pend1_clear got=%0d exp=1", pc_select); end
    m = '0; m[3] = 1'b1; elig(m);
    #1;
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL sc_pend3_set got=%0b exp=0", fetch_valid); end
    @(negedge clk);
    icache_ack      = 1'b1;
    icache_ack_wfid = 6'd3;
    @(negedge clk);
    icache_ack = 1'b0;
    #1;
    total++; if (credits !== 5'd31) begin bad++; $display("FAIL sc_restore got=%0d exp=31", credits); end
  endtask

  task automatic test_fixed();
    logic [NW-1:0] m;
    // Pointer is 4 here, so round-robin would pick 7 rather than 2.
    @(negedge clk);
    arb_mode = ARB_FIXED;
    m = '0; m[2] = 1'b1; m[7] = 1'b1;
    vacant      = '0;
    queue_vfull = ~m;
    fetch_ready = 1'b1;
    #1;
    total++; if (pc_select !== 6'd2) begin bad++; $display("FAIL fx_pc2 got=%0d exp=2", pc_select); end
    @(negedge clk);
    #1;
    total++; if (pc_select !== 6'd7) begin bad++; $display("FAIL fx_pc7 got=%0d exp=7", pc_select); end
    total++; if (credits !== 5'd30) begin bad++; $display("FAIL fx_credits_a got=%0d exp=30", credits); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      fetch_ready = 1'b0;
      m = '0; m[1] = 1'b1; m[9] = 1'b1;
      queue_vfull = ~m;
      #1;
      total++; if (fetch_valid !== 1'b1) begin bad++; $display("FAIL fx_hold_valid[%0d] got=%0b exp=1", c, fetch_valid); end
      total++; if (pc_select !== 6'd1) begin bad++; $display("FAIL fx_hold_pc[%0d] got=%0d exp=1", c, pc_select); end
      total++; if (credits !== 5'd29) begin bad++; $display("FAIL fx_hold_credits[%0d] got=%0d exp=29", c, credits); end
    end
    // Mode switch is immediate; pointer advanced to 8 during fixed-mode grants.
    arb_mode = ARB_RR;
    #1;
    total++; if (pc_select !== 6'd9) begin bad++; $display("FAIL fx_mode_switch got=%0d exp=9", pc_select); end
    @(negedge clk);
    icache_ack      = 1'b1;
    icache_ack_wfid = 6'd2;
    @(negedge clk);
    icache_ack_wfid = 6'd7;
    @(negedge clk);
    icache_ack  = 1'b0;
    queue_vfull = '0;
    #1;
    total++; if (credits !== 5'd31) begin bad++; $display("FAIL fx_restore got=%0d exp=31", credits); end
  endtask

  task automatic test_credit_exhaust();
    @(negedge clk);
    elig('1);
    fetch_ready  = 1'b0;
    fetch_ready2 = 1'b1;
    #1;
    total++; if (fetch_valid2 !== 1'b1) begin bad++; $display("FAIL ce_valid0 got=%0b exp=1", fetch_valid2); end
    total++; if (pc_select2 !== 6'd0) begin bad++; $display("FAIL ce_pc0 got=%0d exp=0", pc_select2); end
    total++; if (credits2 !== 2'd2) begin bad++; $display("FAIL ce_credits0 got=%0d exp=2", credits2); end
    @(negedge clk);
    #1;
    total++; if (pc_select2 !== 6'd1) begin bad++; $display("FAIL ce_pc1 got=%0d exp=1", pc_select2); end
    total++; if (credits2 !== 2'd1) begin bad++; $display("FAIL ce_credits1 got=%0d exp=1", credits2); end
    @(negedge clk);
    #1;
    total++; if (credits2 !== 2'd0) begin bad++; $display("FAIL ce_credits_empty got=%0d exp=0", credits2); end
    total++; if (fetch_valid2 !== 1'b0) begin bad++; $display("FAIL ce_valid_empty got=%0b exp=0", fetch_valid2); end
    @(negedge clk);
    icache_ack2      = 1'b1;
    icache_ack_wfid2 = 6'd0;
    #1;
    total++; if (fetch_valid2 !== 1'b0) begin bad++; $display("FAIL ce_valid_ackcyc got=%0b exp=0", fetch_valid2); end
    @(negedge clk);
    icache_ack2  = 1'b0;
    fetch_ready2 = 1'b0;
    #1;
    total++; if (credits2 !== 2'd1) begin bad++; $display("FAIL ce_credits_back got=%0d exp=1", credits2); end
    total++; if (fetch_valid2 !== 1'b1) begin bad++; $display("FAIL ce_valid_back got=%0b exp=1", fetch_valid2); end
    total++; if (pc_select2 !== 6'd2) begin bad++; $display("FAIL ce_pc_back got=%0d exp=2", pc_select2); end
    // Out-of-range ID flags an error and leaves credits alone.
    @(negedge clk);
    icache_ack2      = 1'b1;
    icache_ack_wfid2 = 6'd45;
    @(negedge clk);
    icache_ack2 = 1'b0;
    #1;
    total++; if (ack_err2 !== 1'b1) begin bad++; $display("FAIL ce_err_range got=%0b exp=1", ack_err2); end
    total++; if (credits2 !== 2'd1) begin bad++; $display("FAIL ce_err_credits got=%0d exp=1", credits2); end
  endtask

  task automatic test_ack_err_reset();
    logic [NW-1:0] m;
    @(negedge clk);
    elig('0);
    icache_ack      = 1'b1;
    icache_ack_wfid = 6'd9;
    #1;
    total++; if (ack_err !== 1'b0) begin bad++; $display("FAIL err_before got=%0b exp=0", ack_err); end
    @(negedge clk);
    icache_ack = 1'b0;
    #1;
    total++; if (ack_err !== 1'b1) begin bad++; $display("FAIL err_set got=%0b exp=1", ack_err); end
    total++; if (credits !== 5'd31) begin bad++; $display("FAIL err_credits got=%0d exp=31", credits); end
    // Pointer is 8; grant slot 5 so it becomes 6 with slot 5 pending.
    @(negedge clk);
    m = '0; m[5] = 1'b1; elig(m);
    fetch_ready = 1'b1;
    #1;
    total++; if (pc_select !== 6'd5) begin bad++; $display("FAIL err_pc5 got=%0d exp=5", pc_select); end
    @(negedge clk);
    fetch_ready = 1'b0;
    #1;
    total++; if (credits !== 5'd30) begin bad++; $display("FAIL err_credits_pre got=%0d exp=30", credits); end
    total++; if (ack_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%0b exp=1", ack_err); end
    rst = 1'b0;
    #1;
    total++; if (credits !== 5'd31) begin bad++; $display("FAIL rst_credits got=%0d exp=31", credits); end
    total++; if (ack_err !== 1'b0) begin bad++; $display("FAIL rst_ack_err got=%0b exp=0", ack_err); end
    total++; if (ack_err2 !== 1'b0) begin bad++; $display("FAIL rst_ack_err2 got=%0b exp=0", ack_err2); end
    total++; if (credits2 !== 2'd2) begin bad++; $display("FAIL rst_credits2 got=%0d exp=2", credits2); end
    @(negedge clk);
    rst = 1'b1;
    m = '0; m[0] = 1'b1; m[7] = 1'b1; elig(m);
    #1;
    total++; if (pc_select !== 6'd0) begin bad++; $display("FAIL rst_ptr got=%0d exp=0", pc_select); end
    m = '0; m[5] = 1'b1; elig(m);
    #1;
    total++; if (fetch_valid !== 1'b1) begin bad++; $display("FAIL rst_pending got=%0b exp=1", fetch_valid); end
    // Ack for a fetch issued before reset is now stale.
    @(negedge clk);
    elig('0);
    icache_ack      = 1'b1;
    icache_ack_wfid = 6'd5;
    @(negedge clk);
    icache_ack = 1'b0;
    #1;
    total++; if (ack_err !== 1'b1) begin bad++; $display("FAIL rst_stale_ack got=%0b exp=1", ack_err); end
    total++; if (credits !== 5'd31) begin bad++; $display("FAIL rst_stale_credits got=%0d exp=31", credits); end
  endtask

  initial begin
    test_reset();
    test_rr_sequence();
    test_wrap();
    test_same_cycle();
    test_fixed();
    test_credit_exhaust();
    test_ack_err_reset();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
